// File: rtl/i2c_slave_regfile_if.sv
// Pad-level bus bundle for the I2C target register file.
//   SCL_PAD_I / SDA_PAD_I    : bus levels seen by the target
//   SDA_PAD_O / SDA_PADOEN_O : open-drain SDA drive (value, active-low enable)
//   BUSY_O                   : transaction in progress (START..STOP)
//   WR_STROBE_O              : one-cycle register write pulse
//   REG_ADDR_O / REG_DATA_O  : index and data of the written register
interface i2c_slave_regfile_if;
  logic       SCL_PAD_I;
  logic       SDA_PAD_I;
  logic       SDA_PAD_O;
  logic       SDA_PADOEN_O;
  logic       BUSY_O;
  logic       WR_STROBE_O;
  logic [7:0] REG_ADDR_O;
  logic [7:0] REG_DATA_O;

  modport slave (
    input  SCL_PAD_I, SDA_PAD_I,
    output SDA_PAD_O, SDA_PADOEN_O, BUSY_O, WR_STROBE_O, REG_ADDR_O, REG_DATA_O
  );

  modport master (
    output SCL_PAD_I, SDA_PAD_I,
    input  SDA_PAD_O, SDA_PADOEN_O, BUSY_O, WR_STROBE_O, REG_ADDR_O, REG_DATA_O
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file. A write sets a pointer byte and then
// stores data bytes at auto-incrementing addresses; a read returns bytes from
// the pointer onward, also auto-incrementing. SCL is never stretched.
// Ports:
//   WB_CLK_I : system clock, samples the bus
//   ARST_I   : asynchronous active-low reset
//   bus      : pad-level signals (slave modport of i2c_slave_regfile_if)
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input logic               WB_CLK_I,
  input logic               ARST_I,
  i2c_slave_regfile_if.slave bus
);

  localparam int unsigned PtrW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]      raw;
  logic [1:0]      s1_q, s2_q, f_q, fp_q;
  logic [CntW-1:0] cnt_q [2];

  assign raw = {bus.SDA_PAD_I, bus.SCL_PAD_I};

  // Synchronizer plus glitch filter: a new level is accepted only after
  // FILTER_LEN consecutive samples disagree with the current filtered level.
  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      f_q  <= 2'b11;
      fp_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      fp_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_f;
  assign sda_f     = f_q[1];
  assign scl_rise  = f_q[0] & ~fp_q[0];
  assign scl_fall  = ~f_q[0] & fp_q[0];
  // SDA may only count as START/STOP while SCL has been stable high.
  assign start_det = ~f_q[1] & fp_q[1] & f_q[0] & fp_q[0];
  assign stop_det  = f_q[1] & ~fp_q[1] & f_q[0] & fp_q[0];

  state_e          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [PtrW-1:0] ptr_q;
  logic            rw_q;
  logic            oen_q, busy_q, wr_strobe_q;
  logic [7:0]      reg_addr_q, reg_data_q;
  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      rx_byte;

  assign rx_byte = {shift_q[6:0], sda_f};

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      oen_q       <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q   <= StAddr;
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
        oen_q     <= 1'b1;
      end else if (stop_det) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        oen_q   <= 1'b1;
      end else if (scl_rise) begin
        unique case (state_q)
          StAddr: begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                rw_q    <= rx_byte[0];
                state_q <= StAddrAck;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            if (rw_q) begin
              // Pointer advances as each read byte is fetched.
              shift_q <= regs_q[ptr_q];
              ptr_q   <= ptr_q + PtrW'(1);
              state_q <= StRdData;
            end else begin
              state_q <= StPtr;
            end
          end
          StPtr: begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_q   <= rx_byte[PtrW-1:0];
              state_q <= StPtrAck;
            end
          end
          StPtrAck: state_q <= StWrData;
          StWrData: begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StWrAck;
          end
          StWrAck: begin
            regs_q[ptr_q] <= shift_q;
            wr_strobe_q   <= 1'b1;
            reg_addr_q    <= 8'(ptr_q);
            reg_data_q    <= shift_q;
            ptr_q         <= ptr_q + PtrW'(1);
            state_q       <= StWrData;
          end
          StRdData: begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StRdAck;
          end
          StRdAck: begin
            if (!sda_f) begin
              shift_q <= regs_q[ptr_q];
              ptr_q   <= ptr_q + PtrW'(1);
              state_q <= StRdData;
            end else begin
              state_q <= StIgnore;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        unique case (state_q)
          StAddrAck, StPtrAck, StWrAck: oen_q <= 1'b0;
          StRdData:                     oen_q <= shift_q[7];
          default:                      oen_q <= 1'b1;
        endcase
      end
    end
  end

  assign bus.SDA_PAD_O    = 1'b0;
  assign bus.SDA_PADOEN_O = oen_q;
  assign bus.BUSY_O       = busy_q;
  assign bus.WR_STROBE_O  = wr_strobe_q;
  assign bus.REG_ADDR_O   = reg_addr_q;
  assign bus.REG_DATA_O   = reg_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
module tb_i2c_slave_regfile;
  localparam int Q = 8;  // clocks per quarter SCL period
  localparam int PhIdle = 0, PhAddr = 1, PhPtr = 2, PhWr = 3, PhRd = 4, PhIgn = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_m, sda_m;
  always #5 clk = ~clk;

  i2c_slave_regfile_if bus ();

  i2c_slave_regfile #(
    .SLAVE_ADDR(7'h50),
    .NUM_REGS  (16),
    .FILTER_LEN(3)
  ) dut (
    .WB_CLK_I(clk),
    .ARST_I  (rst_n),
    .bus     (bus)
  );

  assign bus.SCL_PAD_I = scl_m;
  assign bus.SDA_PAD_I = sda_m & (bus.SDA_PADOEN_O | bus.SDA_PAD_O);

  int checks = 0;
  int errors = 0;

  // Byte-level model of the target.
  logic [7:0]  m_regs [16];
  int          m_ptr;
  int          phase;
  logic [15:0] exp_q [$];
  logic [15:0] e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    phase = PhIdle;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic g, output logic r);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    r = bus.SDA_PAD_I;
    if (g) begin
      sda_m = ~b;
      wait_clk(1);
      sda_m = b;
      wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
    phase = PhAddr;
    check("busy_after_start", bus.BUSY_O, 1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
    phase = PhIdle;
    check("busy_after_stop", bus.BUSY_O, 0);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
    logic r;
    logic exp;
    exp = 1'b1;
    // Model updated before the bus transfer so strobe expectations are queued in time.
    case (phase)
      PhAddr: begin
        if (b[7:1] == 7'h50) begin
          exp   = 1'b0;
          phase = b[0] ? PhRd : PhPtr;
        end else begin
          phase = PhIgn;
        end
      end
      PhPtr: begin
        exp   = 1'b0;
        m_ptr = int'(b) % 16;
        phase = PhWr;
      end
      PhWr: begin
        exp = 1'b0;
        exp_q.push_back({8'(m_ptr), b});
        m_regs[m_ptr] = b;
        m_ptr = (m_ptr + 1) % 16;
      end
      default: exp = 1'b1;
    endcase
    for (int i = 7; i >= 0; i--) send_bit(b[i], gmask[i], r);
    send_bit(1'b1, 1'b0, ack);
    check("ack", ack, exp);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] got);
    logic r;
    logic [7:0] exp;
    if (phase == PhRd) begin
      exp   = m_regs[m_ptr];
      m_ptr = (m_ptr + 1) % 16;
      if (nack) phase = PhIgn;
    end else begin
      exp = 8'hFF;
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, r);
      got[i] = r;
    end
    send_bit(nack, 1'b0, r);
    check("rd_data", got, exp);
  endtask

  // Every cycle out of reset: SDA_PAD_O constant and strobes match the model queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (bus.SDA_PAD_O !== 1'b0) begin
        errors++;
        $display("FAIL sda_pad_o got=%b exp=0 at %0t", bus.SDA_PAD_O, $time);
      end
      if (bus.WR_STROBE_O !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_spurious got=%h/%h exp=none at %0t",
                   bus.REG_ADDR_O, bus.REG_DATA_O, $time);
        end else begin
          e = exp_q.pop_front();
          if ({bus.REG_ADDR_O, bus.REG_DATA_O} !== e) begin
            errors++;
            $display("FAIL strobe got=%h/%h exp=%h/%h at %0t",
                     bus.REG_ADDR_O, bus.REG_DATA_O, e[15:8], e[7:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] got;
    int         kind, n, a;

    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    model_reset();
    wait_clk(5);
    @(negedge clk);
    check("rst_oen", bus.SDA_PADOEN_O, 1);
    check("rst_busy", bus.BUSY_O, 0);
    check("rst_strobe", bus.WR_STROBE_O, 0);
    check("rst_addr", bus.REG_ADDR_O, 0);
    check("rst_data", bus.REG_DATA_O, 0);
    rst_n = 1'b1;
    wait_clk(2 * Q);

    // Write two bytes from pointer 3.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h03, 8'h00, ack);
    wr_byte(8'h5A, 8'h00, ack);
    wr_byte(8'hC3, 8'h00, ack);
    check("lit_ack_data", ack, 0);
    i2c_stop();

    // Random read via pointer write plus repeated START.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h03, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    rd_byte(1'b0, got);
    check("lit_rd_5a", got, 8'h5A);
    rd_byte(1'b1, got);
    check("lit_rd_c3", got, 8'hC3);
    check("oen_after_nack", bus.SDA_PADOEN_O, 1);
    i2c_stop();

    // Address mismatch: no ACK, following bytes ignored.
    i2c_start();
    wr_byte(8'hA2, 8'h00, ack);
    check("lit_nack_addr", ack, 1);
    wr_byte(8'h55, 8'h00, ack);
    wr_byte(8'h66, 8'h00, ack);
    i2c_stop();

    // Wrap: regs[1] marked, then write across 15 -> 0 leaves pointer at 1.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h01, 8'h00, ack);
    wr_byte(8'h77, 8'h00, ack);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h0F, 8'h00, ack);
    wr_byte(8'h11, 8'h00, ack);
    wr_byte(8'h22, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    rd_byte(1'b1, got);
    check("lit_ptr_wrapped", got, 8'h77);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h0F, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    rd_byte(1'b0, got);
    check("lit_reg15", got, 8'h11);
    rd_byte(1'b1, got);
    check("lit_reg0", got, 8'h22);
    i2c_stop();

    // One-cycle SDA glitch on an idle bus is not a START.
    sda_m = 1'b0;
    wait_clk(1);
    sda_m = 1'b1;
    wait_clk(2 * Q);
    check("glitch_idle_busy", bus.BUSY_O, 0);

    // Glitches while SCL is high on a 1 bit and on a 0 bit do not disturb the byte.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h05, 8'h00, ack);
    wr_byte(8'h3C, 8'h48, ack);
    i2c_stop();

    // STOP after 4 bits of a data byte aborts it.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h06, 8'h00, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, ack);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h06, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    rd_byte(1'b1, got);
    check("lit_abort_reg6", got, 8'h00);
    i2c_stop();

    // Randomized transactions against the model.
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      i2c_start();
      if (kind == 0) begin
        wr_byte(8'hA0, 8'h00, ack);
        wr_byte(8'($urandom_range(0, 255)), 8'h00, ack);
        for (int k = 0; k < n; k++) wr_byte(8'($urandom_range(0, 255)), 8'h00, ack);
      end else if (kind == 1) begin
        wr_byte(8'hA0, 8'h00, ack);
        wr_byte(8'($urandom_range(0, 255)), 8'h00, ack);
        i2c_start();
        wr_byte(8'hA1, 8'h00, ack);
        for (int k = 0; k < n; k++) rd_byte(k == n - 1, got);
      end else begin
        a = $urandom_range(0, 127);
        if (a == 'h50) a = 'h51;
        wr_byte({7'(a), 1'($urandom_range(0, 1))}, 8'h00, ack);
        wr_byte(8'($urandom_range(0, 255)), 8'h00, ack);
      end
      i2c_stop();
    end

    // Reset while the target drives a 0 data bit.
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h03, 8'h00, ack);
    wr_byte(8'h5A, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h03, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    wait_clk(4);
    @(negedge clk);
    check("drive_before_rst", bus.SDA_PADOEN_O, 0);
    rst_n = 1'b0;
    #1;
    check("oen_at_rst", bus.SDA_PADOEN_O, 1);
    check("busy_at_rst", bus.BUSY_O, 0);
    model_reset();
    sda_m = 1'b1;
    wait_clk(2);
    scl_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2 * Q);
    i2c_start();
    wr_byte(8'hA0, 8'h00, ack);
    wr_byte(8'h03, 8'h00, ack);
    i2c_start();
    wr_byte(8'hA1, 8'h00, ack);
    rd_byte(1'b1, got);
    check("lit_reg3_after_rst", got, 8'h00);
    i2c_stop();

    wait_clk(4);
    check("strobe_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
I2C target (slave) with an internal byte register file. It is the far end of the bus driven by the Wishbone I2C master, sharing the same SCL/SDA pad nets. The master can write registers through a pointer byte and read them back with pointer auto-increment. It serves as both a synthesizable peripheral and the bus responder for the master's verification bench.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
NUM_REGS, 16, register file depth; power of 2, 2..256.
FILTER_LEN, 3, consecutive identical synchronized samples required to accept a new SCL/SDA level.

Ports:
WB_CLK_I  input  1  system clock; samples the bus.
ARST_I  input  1  asynchronous active-low reset.
SCL_PAD_I  input  1  bus SCL level.
SDA_PAD_I  input  1  bus SDA level.
SDA_PAD_O  output  1  SDA drive value; constant 0 (open-drain).
SDA_PADOEN_O  output  1  SDA output enable, active-low; 0 pulls SDA low.
BUSY_O  output  1  high from START until STOP.
WR_STROBE_O  output  1  one-cycle pulse when a register is written.
REG_ADDR_O  output  8  index of the register written; valid with WR_STROBE_O.
REG_DATA_O  output  8  data written; valid with WR_STROBE_O.

Behaviour:
- Reset (ARST_I=0, asynchronous): SDA_PADOEN_O=1, SDA_PAD_O=0, BUSY_O=0, WR_STROBE_O=0, REG_ADDR_O=0, REG_DATA_O=0. All registers are 0, pointer is 0, state is IDLE. Reset asserted mid-transfer releases SDA immediately.
- Input path: 2-FF synchronizer on each input, then a FILTER_LEN glitch filter. Edges are detected on the filtered signals.
- START: filtered SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are recognized in any state; START includes repeated START.
  - START: go to ADDR, set BUSY_O=1, clear the bit counter, release SDA.
  - STOP: go to IDLE, set BUSY_O=0, release SDA.
- Data bits are sampled on the filtered SCL rising edge, MSB first. SDA_PADOEN_O changes only on the cycle after a filtered SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On match of bits[7:1] with SLAVE_ADDR, go to ADDR_ACK. On mismatch, go to IGNORE and never drive.
  - ADDR_ACK: drive SDA low for the 9th clock. Then if R/W=0 go to PTR. If R/W=1, load the shift register from regs[ptr] and go to RD_DATA.
  - PTR: shift 8 bits; ptr <= byte modulo NUM_REGS; go to PTR_ACK, which ACKs, then WR_DATA.
  - WR_DATA: shift 8 bits; go to WR_ACK. WR_ACK ACKs, and on the 9th SCL rising edge:
    - regs[ptr] <= byte;
    - pulse WR_STROBE_O for 1 cycle with REG_ADDR_O=ptr and REG_DATA_O=byte;
    - ptr <= (ptr+1) mod NUM_REGS;
    - return to WR_DATA.
  - RD_DATA: after each SCL falling edge, drive the current MSB (SDA_PADOEN_O=0 for a 0 bit, 1 for a 1 bit). After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on the 9th rising edge. Every read byte advances ptr mod NUM_REGS.
    - ACK (0): load regs[ptr] and return to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer wraps from NUM_REGS-1 to 0 for both reads and writes.
- A write transaction with no data bytes (STOP after PTR_ACK) sets only the pointer. A following repeated-START read uses that pointer.
- A STOP or START arriving mid-byte aborts the byte with no register update and no strobe.
- SCL is never stretched; the target has no SCL outputs.

Test Plan:
- Write: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes. WR_STROBE_O pulses (0x03,0x5A) then (0x04,0xC3). BUSY_O falls after STOP.
- Random read: write ptr 0x03, repeated START, 0xA1, read 2 bytes with ACK then NACK -> bus returns 0x5A then 0xC3. SDA is released after the NACK.
- Address mismatch: START, 0xA2 -> no ACK (SDA stays 1 at the 9th clock). Subsequent bytes are ignored and no strobe fires.
- Wrap: ptr 0x0F, write 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22. Pointer then equals 1.
- Glitch/abort: 1-cycle SDA glitch while SCL is high gives no START/STOP detection. A STOP after 4 bits of a data byte means no register change, no strobe, and IDLE.
- Reset mid-read while the target drives SDA low -> SDA_PADOEN_O=1 in the same cycle as ARST_I falls. Registers read back 0x00 after reset.
